sa_col_collector: RTL and testbench

Result collector at the bottom of one systolic-array column, directly downstream of the last PE in that column. It counts weight-load handshakes to report when the column's weights are fixed. During calculation it samples the column's partial sums at the cycle each finished dot product emerges, optionally applies ReLU, and buffers the results in a FIFO. The FIFO drains to the NICE-side writeback logic over a valid/ready interface.

---
 rtl/sa_col_collector.sv | 172 +++++++++++++++++
 tb/tb_sa_col_collector.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_col_collector.sv
// Collector at the foot of one systolic-array column: tracks weight-load handshakes,
// samples finished dot products from the bottom PE, applies optional ReLU and queues results.
module sa_col_collector #(
    parameter int ROWS  = 4,
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic                    PE_clk,
    input  logic                    PE_rst_n,
    input  logic                    PE_en_down,
    input  logic signed [31:0]      PE_data_down,
    input  logic                    clr,
    input  logic                    calc_start,
    input  logic [LEN_W-1:0]        calc_len,
    input  logic                    relu_en,
    output logic                    wload_done,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [31:0]      out_data,
    input  logic                    out_ready,
    output logic                    ovf_err,
    output logic                    start_err
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WL_W   = $clog2(ROWS + 1);
    localparam int WT_W   = (ROWS > 2) ? $clog2(ROWS - 1) : 1;

    localparam logic [WL_W-1:0]  WL_MAX  = WL_W'(ROWS);
    localparam logic [WT_W-1:0]  WT_LOAD = WT_W'((ROWS >= 2) ? ROWS - 2 : 0);
    localparam logic [CNT_W-1:0] FULL_N  = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;

    function automatic logic signed [DATA_W-1:0] relu_clamp(
        input logic signed [DATA_W-1:0] x,
        input logic                     en
    );
        return (en && x[DATA_W-1]) ? '0 : x;
    endfunction

    logic [WL_W-1:0]  wl_cnt;
    logic [1:0]       state;
    logic [WT_W-1:0]  wait_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] k_q;
    logic             relu_q;
    logic             start_ok;

    logic                     vld_p0;
    logic signed [DATA_W-1:0] cap_data_p0;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     push;
    logic                     pop;

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            wl_cnt <= '0;
        end else if (clr) begin
            wl_cnt <= '0;
        end else if (PE_en_down && wl_cnt != WL_MAX) begin
            wl_cnt <= wl_cnt + WL_W'(1);
        end
    end

    assign wload_done = (wl_cnt == WL_MAX);
    assign busy       = (state != IDLE);
    assign start_ok   = calc_start && (state == IDLE) && (calc_len != '0);

    // wait_cnt holds the WAIT cycles left before vector 0 leaves the bottom PE.
    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            len_q     <= '0;
            k_q       <= '0;
            relu_q    <= 1'b0;
            start_err <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            len_q     <= '0;
            k_q       <= '0;
            relu_q    <= 1'b0;
            start_err <= 1'b0;
        end else begin
            if (calc_start && state != IDLE) begin
                start_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q    <= calc_len;
                        relu_q   <= relu_en;
                        k_q      <= '0;
                        wait_cnt <= WT_LOAD;
                        state    <= (ROWS == 1) ? CAPT : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WT_W'(1);
                    if (wait_cnt == '0) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    k_q <= k_q + LEN_W'(1);
                    if (k_q == len_q - LEN_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: capture of the bottom-PE sum into the FIFO write port.
    assign vld_p0      = (state == CAPT);
    assign cap_data_p0 = relu_clamp(PE_data_down, relu_q);

    assign full      = (count == FULL_N);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = vld_p0 && (!full || pop);

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (vld_p0 && full && !pop) begin
                ovf_err <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge PE_clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= cap_data_p0;
        end
    end

    // Empty FIFO shows zero so stale storage never leaks after reset or clr.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sa_col_collector.sv
// Bench for sa_col_collector: per-cycle table vectors, directed corner sequences and
// a randomized run, all compared against a queue-based model of the column timing rules.
module tb_sa_col_collector;
    localparam int ROWS  = 4;
    localparam int DEPTH = 8;
    localparam int LEN_W = 8;
    localparam logic signed [31:0] FILL = 32'sh0000_5555;

    logic               PE_clk;
    logic               PE_rst_n;
    logic               PE_en_down;
    logic signed [31:0] PE_data_down;
    logic               clr;
    logic               calc_start;
    logic [LEN_W-1:0]   calc_len;
    logic               relu_en;
    logic               wload_done;
    logic               busy;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic               out_ready;
    logic               ovf_err;
    logic               start_err;

    sa_col_collector #(.ROWS(ROWS), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .PE_clk      (PE_clk),
        .PE_rst_n    (PE_rst_n),
        .PE_en_down  (PE_en_down),
        .PE_data_down(PE_data_down),
        .clr         (clr),
        .calc_start  (calc_start),
        .calc_len    (calc_len),
        .relu_en     (relu_en),
        .wload_done  (wload_done),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .ovf_err     (ovf_err),
        .start_err   (start_err)
    );

    initial PE_clk = 1'b0;
    always #5 PE_clk = ~PE_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: job window in absolute cycle numbers plus a result queue.
    int                 m_wl;
    logic signed [31:0] m_q[$];
    bit                 m_act;
    int                 m_T;
    int                 m_len;
    bit                 m_relu;
    bit                 m_ovf;
    bit                 m_serr;

    typedef struct {
        logic               start;
        logic [LEN_W-1:0]   len;
        logic               relu;
        logic signed [31:0] data;
        logic               ready;
        logic               eb;
        logic               ev;
        logic signed [31:0] ed;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_busy_at(int c);
        return m_act && (c >= m_T + 1) && (c <= m_T + ROWS + m_len - 1);
    endfunction

    task automatic model_clear();
        m_wl = 0;
        m_q.delete();
        m_act = 0;
        m_T = 0;
        m_len = 0;
        m_relu = 0;
        m_ovf = 0;
        m_serr = 0;
    endtask

    task automatic check_model();
        logic [31:0] e;
        e = (m_q.size() != 0) ? m_q[0] : 32'd0;
        chk("wload_done", wload_done, m_wl == ROWS);
        chk("busy", busy, m_busy_at(cyc));
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("out_data", out_data, e);
        chk("ovf_err", ovf_err, m_ovf);
        chk("start_err", start_err, m_serr);
    endtask

    task automatic tick();
        logic signed [31:0] pv;
        bit do_push;
        bit do_pop;
        bit busy_now;
        if (clr) begin
            model_clear();
        end else begin
            busy_now = m_busy_at(cyc);
            do_pop   = (m_q.size() > 0) && out_ready;
            do_push  = m_act && (cyc >= m_T + ROWS) && (cyc <= m_T + ROWS + m_len - 1);
            pv       = (m_relu && PE_data_down < 0) ? 32'sd0 : PE_data_down;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(pv);
                else m_ovf = 1;
            end
            if (calc_start) begin
                if (busy_now) m_serr = 1;
                else if (calc_len != 0) begin
                    m_act  = 1;
                    m_T    = cyc;
                    m_len  = calc_len;
                    m_relu = relu_en;
                end
            end
            if (PE_en_down && m_wl < ROWS) m_wl++;
        end
        @(posedge PE_clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic idle_inputs();
        PE_en_down   = 0;
        PE_data_down = FILL;
        clr          = 0;
        calc_start   = 0;
        calc_len     = 0;
        relu_en      = 0;
    endtask

    task automatic do_clr();
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
    endtask

    function automatic vec_t mk(logic st, logic [LEN_W-1:0] ln, logic rl, logic signed [31:0] d,
                                logic rdy, logic eb, logic ev, logic signed [31:0] ed);
        vec_t v;
        v.start = st; v.len = ln; v.relu = rl; v.data = d; v.ready = rdy;
        v.eb = eb; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic add_job(logic rl, logic signed [31:0] d0, logic signed [31:0] d1, logic signed [31:0] d2,
                           logic signed [31:0] e0, logic signed [31:0] e1, logic signed [31:0] e2);
        tbl.push_back(mk(1, 3, rl, FILL, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, FILL, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, d0, 1, 1, 1, e0));
        tbl.push_back(mk(0, 0, 0, d1, 1, 1, 1, e1));
        tbl.push_back(mk(0, 0, 0, d2, 1, 0, 1, e2));
        tbl.push_back(mk(0, 0, 0, FILL, 1, 0, 0, 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        PE_rst_n  = 0;
        out_ready = 0;
        idle_inputs();
        model_clear();

        add_job(0, 100, -5, 7, 100, -5, 7);
        add_job(1, 100, -5, 7, 100, 0, 7);
        add_job(1, 32'sh8000_0000, 3, 32'sh7FFF_FFFF, 0, 3, 32'sh7FFF_FFFF);

        #2;
        chk("rst_wload_done", wload_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf_err", ovf_err, 0);
        chk("rst_start_err", start_err, 0);
        #10;
        PE_rst_n = 1;

        // Weight load: four non-contiguous pulses, a fifth, then clr.
        do_clr();
        PE_en_down = 1; tick();
        PE_en_down = 0; tick(); tick();
        PE_en_down = 1; tick();
        PE_en_down = 0; tick();
        PE_en_down = 1; tick();
        chk("wl_after_3", wload_done, 0);
        PE_en_down = 0; tick();
        PE_en_down = 1; tick();
        chk("wl_after_4", wload_done, 1);
        tick();
        chk("wl_after_5", wload_done, 1);
        PE_en_down = 0; clr = 1; tick(); clr = 0;
        chk("wl_after_clr", wload_done, 0);

        // Table-driven capture and ReLU jobs.
        out_ready = 1;
        do_clr();
        foreach (tbl[i]) begin
            calc_start   = tbl[i].start;
            calc_len     = tbl[i].len;
            relu_en      = tbl[i].relu;
            PE_data_down = tbl[i].data;
            out_ready    = tbl[i].ready;
            tick();
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
        end
        idle_inputs();

        // Overflow: len=10 with no consumer keeps the first DEPTH samples.
        out_ready = 0;
        do_clr();
        calc_start = 1; calc_len = 10;
        tick();
        calc_start = 0; calc_len = 0;
        for (int r = 1; r <= ROWS + 10 - 1; r++) begin
            PE_data_down = (r >= ROWS) ? 32'sd1000 + (r - ROWS) : FILL;
            tick();
            if (r == ROWS + 10 - 2) chk("ovf_busy_before_end", busy, 1);
        end
        PE_data_down = FILL;
        chk("ovf_busy_end", busy, 0);
        chk("ovf_flag", ovf_err, 1);
        chk("ovf_valid", out_valid, 1);
        out_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("ovf_head%0d", k), out_data, 32'd1000 + k);
            tick();
        end
        chk("ovf_drained", out_valid, 0);

        // calc_start during WAIT is ignored and flagged.
        out_ready = 0;
        do_clr();
        calc_start = 1; calc_len = 3; tick();
        calc_start = 0; tick();
        calc_start = 1; calc_len = 5; tick();
        calc_start = 0; calc_len = 0;
        chk("serr_flag", start_err, 1);
        for (int r = 3; r < 14; r++) begin
            PE_data_down = 32'sd200 + r;
            tick();
        end
        PE_data_down = FILL;
        out_ready = 1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) n++;
            tick();
        end
        chk("serr_capture_count", n, 3);

        // calc_len = 0 is a no-op.
        do_clr();
        calc_start = 1; calc_len = 0; tick();
        calc_start = 0;
        for (int i = 0; i < 8; i++) begin
            PE_data_down = 32'sd42;
            tick();
            chk("len0_busy", busy, 0);
            chk("len0_valid", out_valid, 0);
        end

        // Async reset mid-CAPT with two entries queued, then a fresh job.
        out_ready = 0;
        do_clr();
        calc_start = 1; calc_len = 6; tick();
        calc_start = 0; calc_len = 0;
        for (int r = 1; r <= 5; r++) begin
            PE_data_down = 32'sd300 + r;
            tick();
        end
        chk("arst_pre_valid", out_valid, 1);
        chk("arst_pre_busy", busy, 1);
        #2;
        PE_rst_n = 0;
        #1;
        model_clear();
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_wload", wload_done, 0);
        chk("arst_ovf", ovf_err, 0);
        chk("arst_serr", start_err, 0);
        #2;
        PE_rst_n = 1;
        out_ready = 1;
        calc_start = 1; calc_len = 2; tick();
        t0 = cyc - 1;
        calc_start = 0; calc_len = 0;
        while (cyc < t0 + ROWS + 3) begin
            PE_data_down = (cyc == t0 + ROWS) ? 32'sd77 : (cyc == t0 + ROWS + 1) ? -32'sd9 : FILL;
            tick();
            if (cyc == t0 + ROWS + 1) chk("post_rst_first", out_data, 77);
            if (cyc == t0 + ROWS + 2) chk("post_rst_second", out_data, -32'sd9);
        end

        // Randomized traffic against the model.
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            clr          = ($urandom_range(0, 99) == 0);
            PE_en_down   = ($urandom_range(0, 4) == 0);
            calc_start   = ($urandom_range(0, 9) == 0);
            calc_len     = LEN_W'($urandom_range(0, 12));
            relu_en      = $urandom_range(0, 1);
            PE_data_down = $urandom;
            out_ready    = ($urandom_range(0, 9) < 6);
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
